// File: rtl/mips_alu_if.sv
// Operand/result bundle between the decode stage and the execute-stage ALU.
// The master side supplies decoded instruction fields; the slave side returns the registered result.
interface mips_alu_if #(
  parameter int WIDTH = 32
);
  logic [5:0]       opcode;
  logic [WIDTH-1:0] rs_content;
  logic [WIDTH-1:0] rt_content;
  logic [4:0]       shamt;
  logic [5:0]       ALU_control;
  logic [15:0]      immediate;
  logic [WIDTH-1:0] ALU_result;
  logic             sig_branch;

  modport master (
    output opcode, rs_content, rt_content, shamt, ALU_control, immediate,
    input  ALU_result, sig_branch
  );

  modport slave (
    input  opcode, rs_content, rt_content, shamt, ALU_control, immediate,
    output ALU_result, sig_branch
  );
endinterface

// File: rtl/mips_alu.sv
// MIPS-style execute-stage ALU: decodes opcode/funct, computes a result and a
// branch-taken flag, and registers both with one cycle of latency.
module mips_alu #(
  parameter int WIDTH = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  mips_alu_if.slave   alu
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_BLEZ  = 6'b000110;
  localparam logic [5:0] OP_BGTZ  = 6'b000111;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_SLLV  = 6'b000100;
  localparam logic [5:0] FN_SRLV  = 6'b000110;
  localparam logic [5:0] FN_SRAV  = 6'b000111;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_ADDU  = 6'b100001;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_SUBU  = 6'b100011;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;
  localparam logic [5:0] FN_SLTU  = 6'b101011;

  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic [WIDTH-1:0] imm_se;
  logic [WIDTH-1:0] imm_ze;
  logic [4:0]       var_sh;
  logic [WIDTH-1:0] diff;
  logic [WIDTH-1:0] result_d;
  logic             branch_d;

  assign rs     = alu.rs_content;
  assign rt     = alu.rt_content;
  assign imm_se = {{(WIDTH-16){alu.immediate[15]}}, alu.immediate};
  assign imm_ze = {{(WIDTH-16){1'b0}}, alu.immediate};
  assign var_sh = rs[4:0];
  assign diff   = rs - rt;

  always_comb begin
    result_d = '0;
    branch_d = 1'b0;
    unique case (alu.opcode)
      OP_RTYPE: begin
        case (alu.ALU_control)
          FN_ADD, FN_ADDU: result_d = rs + rt;
          FN_SUB, FN_SUBU: result_d = diff;
          FN_AND:          result_d = rs & rt;
          FN_OR:           result_d = rs | rt;
          FN_XOR:          result_d = rs ^ rt;
          FN_NOR:          result_d = ~(rs | rt);
          FN_SLT:          result_d = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(rt))};
          FN_SLTU:         result_d = {{(WIDTH-1){1'b0}}, (rs < rt)};
          FN_SLL:          result_d = rt << alu.shamt;
          FN_SRL:          result_d = rt >> alu.shamt;
          FN_SRA:          result_d = $unsigned($signed(rt) >>> alu.shamt);
          FN_SLLV:         result_d = rt << var_sh;
          FN_SRLV:         result_d = rt >> var_sh;
          FN_SRAV:         result_d = $unsigned($signed(rt) >>> var_sh);
          default:         result_d = '0;
        endcase
      end
      OP_ADDI, OP_ADDIU, OP_LW, OP_SW: result_d = rs + imm_se;
      OP_SLTI:  result_d = {{(WIDTH-1){1'b0}}, ($signed(rs) < $signed(imm_se))};
      OP_SLTIU: result_d = {{(WIDTH-1){1'b0}}, (rs < imm_se)};
      OP_ANDI:  result_d = rs & imm_ze;
      OP_ORI:   result_d = rs | imm_ze;
      OP_XORI:  result_d = rs ^ imm_ze;
      OP_LUI:   result_d = {alu.immediate, 16'h0000};
      OP_BEQ: begin
        result_d = diff;
        branch_d = (rs == rt);
      end
      OP_BNE: begin
        result_d = diff;
        branch_d = (rs != rt);
      end
      // blez/bgtz only look at rs; the result forwards rs unchanged
      OP_BLEZ: begin
        result_d = rs;
        branch_d = ($signed(rs) <= 0);
      end
      OP_BGTZ: begin
        result_d = rs;
        branch_d = ($signed(rs) > 0);
      end
      default: begin
        result_d = '0;
        branch_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu.ALU_result <= '0;
      alu.sig_branch <= 1'b0;
    end else begin
      alu.ALU_result <= result_d;
      alu.sig_branch <= branch_d;
    end
  end

endmodule

// File: tb/tb_mips_alu.sv
// Directed-vector bench for mips_alu: each step drives one instruction and
// checks the registered result and branch flag one clock later.
module tb_mips_alu;

  logic clk;
  logic rst_n;
  int   n_tests;
  int   n_fail;

  mips_alu_if #(.WIDTH(32)) alu_bus ();

  mips_alu #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .alu   (alu_bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] res_exp, input logic br_exp);
    n_tests++;
    assert (alu_bus.ALU_result === res_exp) else begin
      n_fail++;
      $error("FAIL %s result: got %h expected %h", tag, alu_bus.ALU_result, res_exp);
    end
    n_tests++;
    assert (alu_bus.sig_branch === br_exp) else begin
      n_fail++;
      $error("FAIL %s branch: got %b expected %b", tag, alu_bus.sig_branch, br_exp);
    end
  endtask

  task automatic drive(input logic [5:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] imm);
    alu_bus.opcode      = op;
    alu_bus.rs_content  = rs;
    alu_bus.rt_content  = rt;
    alu_bus.shamt       = sh;
    alu_bus.ALU_control = fn;
    alu_bus.immediate   = imm;
  endtask

  // drive at the falling edge, capture on the rising edge, sample 1 ns later
  task automatic step(input string tag, input logic [5:0] op, input logic [31:0] rs,
                      input logic [31:0] rt, input logic [4:0] sh, input logic [5:0] fn,
                      input logic [15:0] imm, input logic [31:0] res_exp, input logic br_exp);
    @(negedge clk);
    drive(op, rs, rt, sh, fn, imm);
    @(posedge clk);
    #1;
    check(tag, res_exp, br_exp);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    drive(6'b000000, 32'hDEAD_BEEF, 32'h1234_5678, 5'd3, 6'b100000, 16'hABCD);
    #1;
    check("reset", 32'h0, 1'b0);

    @(negedge clk);
    rst_n = 1'b1;

    // AND
    step("and_15_12", 6'b000000, 32'd15, 32'd12, 5'd0, 6'b100100, 16'h0, 32'd12, 1'b0);
    step("and_23_2",  6'b000000, 32'd23, 32'd2,  5'd0, 6'b100100, 16'h0, 32'd2,  1'b0);
    step("and_1_35",  6'b000000, 32'd1,  32'd35, 5'd0, 6'b100100, 16'h0, 32'd1,  1'b0);

    // arithmetic / compare
    step("add_wrap", 6'b000000, 32'h7FFF_FFFF, 32'd1, 5'd0, 6'b100000, 16'h0, 32'h8000_0000, 1'b0);
    step("sub_neg",  6'b000000, 32'd5, 32'd7, 5'd0, 6'b100010, 16'h0, 32'hFFFF_FFFE, 1'b0);
    step("slt_m1",   6'b000000, 32'hFFFF_FFFF, 32'd1, 5'd0, 6'b101010, 16'h0, 32'd1, 1'b0);
    step("sltu_m1",  6'b000000, 32'hFFFF_FFFF, 32'd1, 5'd0, 6'b101011, 16'h0, 32'd0, 1'b0);
    step("slt_min",  6'b000000, 32'h8000_0000, 32'd0, 5'd0, 6'b101010, 16'h0, 32'd1, 1'b0);
    step("sltu_min", 6'b000000, 32'h8000_0000, 32'd0, 5'd0, 6'b101011, 16'h0, 32'd0, 1'b0);
    step("nor",      6'b000000, 32'hF0F0_0000, 32'h0000_00FF, 5'd0, 6'b100111, 16'h0, 32'h0F0F_FF00, 1'b0);
    step("xor",      6'b000000, 32'hFFFF_0000, 32'h0F0F_0F0F, 5'd0, 6'b100110, 16'h0, 32'hF0F0_0F0F, 1'b0);
    step("bad_fn",   6'b000000, 32'd9, 32'd9, 5'd0, 6'b111111, 16'h0, 32'd0, 1'b0);

    // shifts
    step("sll_31",   6'b000000, 32'd0, 32'd1, 5'd31, 6'b000000, 16'h0, 32'h8000_0000, 1'b0);
    step("sll_0",    6'b000000, 32'd0, 32'hA5A5_1234, 5'd0, 6'b000000, 16'h0, 32'hA5A5_1234, 1'b0);
    step("sra_4",    6'b000000, 32'd0, 32'h8000_0000, 5'd4, 6'b000011, 16'h0, 32'hF800_0000, 1'b0);
    step("srl_4",    6'b000000, 32'd0, 32'h8000_0000, 5'd4, 6'b000010, 16'h0, 32'h0800_0000, 1'b0);
    step("srlv",     6'b000000, 32'h24, 32'hF0, 5'd0, 6'b000110, 16'h0, 32'h0F, 1'b0);
    step("srav",     6'b000000, 32'h28, 32'h8000_0000, 5'd1, 6'b000111, 16'h0, 32'hFF80_0000, 1'b0);

    // immediate forms
    step("addi_m1",  6'b001000, 32'd10, 32'd0, 5'd0, 6'b0, 16'hFFFF, 32'd9, 1'b0);
    step("ori_ze",   6'b001101, 32'd0, 32'd0, 5'd0, 6'b0, 16'h8001, 32'h0000_8001, 1'b0);
    step("lui",      6'b001111, 32'hFFFF_FFFF, 32'd0, 5'd0, 6'b100000, 16'h1234, 32'h1234_0000, 1'b0);
    step("lw_ea",    6'b100011, 32'h100, 32'd0, 5'd0, 6'b0, 16'hFFFC, 32'hFC, 1'b0);
    step("slti",     6'b001010, 32'd5, 32'd0, 5'd0, 6'b0, 16'hFFFF, 32'd0, 1'b0);
    step("sltiu",    6'b001011, 32'd5, 32'd0, 5'd0, 6'b0, 16'hFFFF, 32'd1, 1'b0);
    step("andi_ze",  6'b001100, 32'hFFFF_FFFF, 32'd0, 5'd0, 6'b0, 16'h8F0F, 32'h0000_8F0F, 1'b0);

    // branches
    step("beq_eq",   6'b000100, 32'd7, 32'd7, 5'd0, 6'b0, 16'h0, 32'd0, 1'b1);
    step("bne_eq",   6'b000101, 32'd7, 32'd7, 5'd0, 6'b0, 16'h0, 32'd0, 1'b0);
    step("bne_ne",   6'b000101, 32'd9, 32'd7, 5'd0, 6'b0, 16'h0, 32'd2, 1'b1);
    step("blez_0",   6'b000110, 32'd0, 32'd3, 5'd0, 6'b0, 16'h0, 32'd0, 1'b1);
    step("bgtz_m1",  6'b000111, 32'hFFFF_FFFF, 32'd0, 5'd0, 6'b0, 16'h0, 32'hFFFF_FFFF, 1'b0);
    step("bgtz_1",   6'b000111, 32'd1, 32'd0, 5'd0, 6'b0, 16'h0, 32'd1, 1'b1);
    step("undef_op", 6'b111111, 32'd7, 32'd7, 5'd0, 6'b100000, 16'h0, 32'd0, 1'b0);

    // mid-stream reset: pending beq result discarded, async clear, then reload
    step("pre_rst",  6'b000100, 32'd4, 32'd4, 5'd0, 6'b0, 16'h0, 32'd0, 1'b1);
    @(negedge clk);
    drive(6'b001111, 32'd0, 32'd0, 5'd0, 6'b0, 16'hBEEF);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst", 32'h0, 1'b0);
    @(posedge clk);
    #1;
    check("rst_hold", 32'h0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst", 32'hBEEF_0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not complete, expected finish before 100000");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/mips_alu.md
Name: mips_alu

Overview:
- 32-bit MIPS-style integer ALU for the execute stage of the single-cycle/pipelined datapath.
- Decodes the primary opcode and, for R-type, the function field (ALU_control).
- Computes a result from rs/rt contents, shamt or the 16-bit immediate, and raises a branch-taken flag.
- Outputs are registered: one clock of latency, cleared by reset.

Parameters:
- WIDTH, 32, datapath width. Behaviour is only defined for 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- opcode  input  6  instruction bits [31:26]
- rs_content  input  32  first source operand
- rt_content  input  32  second source operand
- shamt  input  5  shift amount, instruction bits [10:6]
- ALU_control  input  6  R-type function field, instruction bits [5:0]
- immediate  input  16  I-type immediate
- ALU_result  output  32  registered result
- sig_branch  output  1  registered branch-taken flag

Behaviour:
- rst_n low (async): ALU_result=0, sig_branch=0 immediately; held while low.
- Each rising clk with rst_n high: combinational result/flag of the current inputs is captured. Latency is exactly 1 cycle; no handshake; a new operation is accepted every cycle.
- Definitions: SE = sign-extended immediate; ZE = zero-extended immediate.
- Arithmetic wraps modulo 2^32. Overflow is never trapped or flagged.
- Shifts use the low 5 bits of rs for variable shifts.
- opcode 000000 (R-type), ALU_control selects:
  - 100000 add, 100001 addu: rs+rt
  - 100010 sub, 100011 subu: rs-rt
  - 100100 and, 100101 or, 100110 xor, 100111 nor (~(rs|rt))
  - 101010 slt: signed rs<rt ? 1 : 0
  - 101011 sltu: unsigned compare
  - 000000 sll: rt<<shamt
  - 000010 srl: logical right by shamt
  - 000011 sra: arithmetic right by shamt
  - 000100 sllv, 000110 srlv, 000111 srav: shift rt by rs[4:0]
  - any other funct: result 0
  - sig_branch=0 for all R-type.
- I-type by opcode:
  - 001000 addi, 001001 addiu: rs+SE
  - 001010 slti: signed rs<SE; 001011 sltiu: unsigned rs<SE
  - 001100 andi, 001101 ori, 001110 xori: use ZE
  - 001111 lui: {immediate,16'h0}
  - 100011 lw, 101011 sw: rs+SE (effective address)
  - 000100 beq: result rs-rt, sig_branch = (rs==rt)
  - 000101 bne: result rs-rt, sig_branch = (rs!=rt)
  - 000110 blez: result rs, sig_branch = signed rs<=0
  - 000111 bgtz: result rs, sig_branch = signed rs>0
  - any other opcode: result 0, sig_branch 0
- ALU_control is ignored for non-zero opcodes; shamt is ignored except for sll/srl/sra.
- Boundaries:
  - shamt=0 passes rt unchanged.
  - 0x7FFFFFFF+1 = 0x80000000 with no flag.
  - slt 0x80000000 vs 0 gives 1; sltu of the same gives 0.
- Reset asserted mid-stream discards the pending capture. The first edge after release loads the current inputs.

Test Plan:
- Reset: rst_n=0 with arbitrary inputs -> ALU_result=0, sig_branch=0 before any clk edge.
- AND (opcode 0, funct 100100), one cycle each: rs=15,rt=12 -> 12; rs=23,rt=2 -> 2; rs=1,rt=35 -> 1; sig_branch stays 0.
- Arithmetic/compare:
  - add 0x7FFFFFFF+1 -> 0x80000000
  - sub 5-7 -> 0xFFFFFFFE
  - slt rs=0xFFFFFFFF, rt=1 -> 1
  - sltu with the same operands -> 0
- Shifts:
  - sll rt=1, shamt=31 -> 0x80000000
  - sra rt=0x80000000, shamt=4 -> 0xF8000000
  - srlv rt=0xF0, rs=0x24 -> 0x0F
- Immediate:
  - addi rs=10, imm=0xFFFF -> 9
  - ori rs=0, imm=0x8001 -> 0x00008001
  - lui imm=0x1234 -> 0x12340000
  - lw rs=0x100, imm=0xFFFC -> 0xFC
- Branches:
  - beq rs=rt=7 -> sig_branch=1, result 0
  - bne rs=rt=7 -> 0
  - blez rs=0 -> 1
  - bgtz rs=0xFFFFFFFF -> 0
  - undefined opcode 111111 -> result 0, sig_branch 0
